// File: rtl/rotate_pkg.sv
// Shared definitions for the rotate_aligner block: FSM states, direction
// encoding and the shift-amount width helper.
package rotate_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  function automatic int unsigned shamt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rotate_aligner_rot_r1.sv
// Combinational N-bit rotate-right-by-one used to step the search candidate.
module rot_r1 #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] din,
  output logic [N-1:0] dout_c
);

  assign dout_c = {din[0], din[N-1:1]};

endmodule

// File: rtl/rotate_aligner.sv
// Sequential rotation recovery: tries one right-rotation per clock until the
// captured word matches the reference pattern, then reports how to undo it.
// Optional build macro: ROTATE_ALIGNER_MIN_DIR_EN (report minimal-distance rotation).
module rotate_aligner
  import rotate_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [N-1:0]                 din,
  input  logic [N-1:0]                 pattern,
  output logic                         busy,
  output logic                         done,
  output logic                         found,
  output logic [shamt_width(N)-1:0]    sh_amt,
  output logic                         dir,
  output logic [N-1:0]                 dout
);

  localparam int unsigned SW = shamt_width(N);

  state_e         state_q, state_d;
  logic [N-1:0]   cand_q, cand_d;
  logic [N-1:0]   pat_q, pat_d;
  logic [SW-1:0]  k_q, k_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           found_q, found_d;
  logic [SW-1:0]  sh_amt_q, sh_amt_d;
  logic           dir_q, dir_d;
  logic [N-1:0]   dout_q, dout_d;
  logic [N-1:0]   cand_rot_c;

  rot_r1 #(.N(N)) u_rot_r1 (
    .din    (cand_q),
    .dout_c (cand_rot_c)
  );

  // Next-state, candidate stepping and result capture
  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    pat_d    = pat_q;
    k_d      = k_q;
    found_d  = found_q;
    sh_amt_d = sh_amt_q;
    dir_d    = dir_q;
    dout_d   = dout_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SEARCH;
          cand_d  = din;
          pat_d   = pattern;
          k_d     = '0;
        end else begin
          state_d = IDLE;
        end
      end
      SEARCH: begin
        if (cand_q == pat_q) begin
          state_d = DONE;
          found_d = 1'b1;
          dout_d  = pat_q;
`ifdef ROTATE_ALIGNER_MIN_DIR_EN
          if (k_q > SW'(N / 2)) begin
            // N-k modulo 2^SW equals the two's complement of k
            sh_amt_d = SW'(0) - k_q;
            dir_d    = DIR_LEFT;
          end else begin
            sh_amt_d = k_q;
            dir_d    = DIR_RIGHT;
          end
`else
          sh_amt_d = k_q;
          dir_d    = DIR_RIGHT;
`endif
        end else if (k_q == SW'(N - 1)) begin
          state_d  = DONE;
          found_d  = 1'b0;
          sh_amt_d = '0;
          dir_d    = DIR_RIGHT;
          // After N-1 steps one more rotation restores the captured din
          dout_d   = cand_rot_c;
        end else begin
          cand_d = cand_rot_c;
          k_d    = k_q + SW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SEARCH);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cand_q   <= '0;
      pat_q    <= '0;
      k_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      sh_amt_q <= '0;
      dir_q    <= DIR_RIGHT;
      dout_q   <= '0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      pat_q    <= pat_d;
      k_q      <= k_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      found_q  <= found_d;
      sh_amt_q <= sh_amt_d;
      dir_q    <= dir_d;
      dout_q   <= dout_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign found  = found_q;
  assign sh_amt = sh_amt_q;
  assign dir    = dir_q;
  assign dout   = dout_q;

endmodule

// File: tb/tb_rotate_aligner.sv
// Scoreboard bench for rotate_aligner: stimulus pushes model results, a
// negedge monitor pops and compares them whenever done is seen.
module tb_rotate_aligner;

  localparam int unsigned N  = 8;
  localparam int unsigned SW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [N-1:0]  din;
  logic [N-1:0]  pattern;
  logic          busy;
  logic          done;
  logic          found;
  logic [SW-1:0] sh_amt;
  logic          dir;
  logic [N-1:0]  dout;

  typedef struct {
    logic          found;
    logic [SW-1:0] sh;
    logic          dir;
    logic [N-1:0]  dout;
    int            lat;
    int            acc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  rotate_aligner #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .din     (din),
    .pattern (pattern),
    .busy    (busy),
    .done    (done),
    .found   (found),
    .sh_amt  (sh_amt),
    .dir     (dir),
    .dout    (dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [N-1:0] rotr(input logic [N-1:0] d, input int k);
    logic [2*N-1:0] dd;
    dd = {d, d} >> k;
    return dd[N-1:0];
  endfunction

  // Reference: smallest right rotation of d that equals p
  function automatic exp_t model(input logic [N-1:0] d, input logic [N-1:0] p);
    exp_t e;
    e.found = 1'b0; e.sh = '0; e.dir = 1'b1; e.dout = d; e.lat = N; e.acc = 0;
    for (int k = 0; k < int'(N); k++) begin
      if (rotr(d, k) == p) begin
        e.found = 1'b1;
        e.dout  = p;
        e.lat   = k + 1;
`ifdef ROTATE_ALIGNER_MIN_DIR_EN
        if (k > int'(N) / 2) begin
          e.sh = SW'(int'(N) - k); e.dir = 1'b0;
        end else begin
          e.sh = SW'(k); e.dir = 1'b1;
        end
`else
        e.sh = SW'(k); e.dir = 1'b1;
`endif
        break;
      end
    end
    return e;
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("found",   int'(found),  int'(e.found));
        check("sh_amt",  int'(sh_amt), int'(e.sh));
        check("dir",     int'(dir),    int'(e.dir));
        check("dout",    int'(dout),   int'(e.dout));
        check("latency", cyc - e.acc,  e.lat);
      end
    end
  end

  // Drive a start that will be accepted at the next edge; push its expectation
  task automatic issue(input logic [N-1:0] d, input logic [N-1:0] p);
    exp_t e;
    start = 1'b1; din = d; pattern = p;
    @(posedge clk); #1;
    e = model(d, p);
    e.acc = cyc;
    exp_q.push_back(e);
    start = 1'b0;
    din = $urandom; pattern = $urandom;
  endtask

  task automatic wait_done(output int busy_cnt);
    bit seen;
    busy_cnt = 0; seen = 0;
    for (int i = 0; i < 2 * int'(N) + 4; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin seen = 1; break; end
    end
    if (!seen) check("done_timeout", 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},   int'(busy),   0);
    check({tag, "_done"},   int'(done),   0);
    check({tag, "_found"},  int'(found),  0);
    check({tag, "_sh_amt"}, int'(sh_amt), 0);
    check({tag, "_dir"},    int'(dir),    1);
    check({tag, "_dout"},   int'(dout),   0);
  endtask

  initial begin
    int bc;
    logic [N-1:0] d, p;
    rst = 1'b1; start = 1'b0; din = '0; pattern = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    issue(8'b10011101, 8'b10110011); wait_done(bc);
    @(negedge clk);
    issue(8'b01110110, 8'b10110011); wait_done(bc);
    @(negedge clk);
    issue(8'h00, 8'hFF); wait_done(bc);
    check("nomatch_busy_cycles", bc, int'(N));
    @(negedge clk);
    check("idle_after_done", int'(busy | done), 0);

    // Back-to-back start held during DONE
    issue(8'hAA, 8'hAA); wait_done(bc);
    issue(8'h55, 8'hAA);
    check("b2b_busy", int'(busy), 1);
    check("b2b_done_fell", int'(done), 0);
    wait_done(bc);
    @(negedge clk);

    // Reset mid-search aborts; start during reset is ignored
    issue(8'h00, 8'hFF);
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b1; din = 8'h3C; pattern = 8'h3C;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check_reset_outputs("abort");
    @(posedge clk); #1;
    check("abort_busy_e3", int'(busy), 0);
    check("abort_done_e3", int'(done), 0);
    repeat (3) @(negedge clk);

    // Randomized traffic, roughly half guaranteed matches
    for (int i = 0; i < 60; i++) begin
      d = N'($urandom);
      p = ($urandom_range(0, 1) == 1) ? rotr(d, int'($urandom_range(0, N - 1))) : N'($urandom);
      issue(d, p);
      wait_done(bc);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rotate_aligner.md
# rotate_aligner

Sequential rotation-recovery block, the receive-side counterpart of the team's N-bit rotate barrel shifter. It accepts a word that was rotated by an unknown amount and a known reference pattern. It then searches one candidate rotation per clock until the rotated input matches the pattern, and reports the rotation amount and direction needed to undo it. It sits downstream of the rotator in alignment and frame-sync paths.

## Interface
- N, 8, data width; power of two, ≥ 4
- clk  input  1  rising-edge clock
- rst  input  1  reset: synchronous, active-high, one clock (clk) domain
- start  input  1  request; sampled only when busy=0
- din  input  N  rotated word, captured on accepted start
- pattern  input  N  reference word, captured on accepted start
- busy  output  1  high while searching
- done  output  1  one-cycle completion pulse
- found  output  1  match found; valid from done onward
- sh_amt  output  $clog2(N)  rotation amount that undoes the input rotation
- dir  output  1  0 = left, 1 = right; direction that undoes the input rotation
- dout  output  N  aligned word: pattern if found, captured din otherwise

## Operation
- FSM states and transitions:
  - IDLE → SEARCH on start.
  - SEARCH → DONE on match, or when k = N-1 with no match.
  - DONE → SEARCH if start is high, otherwise DONE → IDLE.
- Accepted start:
  - Captures din into cand and pattern into pat_q.
  - Sets k=0.
- Each SEARCH cycle:
  - Compare cand == pat_q.
  - On mismatch: cand ← cand rotated right by 1, k ← k+1.
- Match at k:
  - found=1, sh_amt=k, dir=1, dout=pat_q.
  - Multiple matches (periodic words such as 8'hAA): the smallest k wins.
- No match after N candidates:
  - found=0, sh_amt=0, dir=1, dout=captured din.
- Result outputs are registered at the SEARCH→DONE edge and hold until the next DONE.
- busy=1 only in SEARCH. done=1 only in DONE.
- start while busy=1 is ignored.
- k is $clog2(N) bits wide. It never wraps, because the search terminates at k = N-1.

## Timing
- Reset values: busy=0, done=0, found=0, sh_amt=0, dir=1, dout=0; state IDLE.
- rst asserted mid-SEARCH or in DONE aborts the search and suppresses done. Everything returns to reset values at that edge.
- Start accepted at edge E0:
  - busy is high from E0.
  - A match at k is registered at edge E0+k+1, and done is high for the cycle after it.
  - The no-match result is registered at E0+N.
- Start during the DONE cycle is accepted back-to-back: no IDLE cycle, and busy rises at the same edge done falls.
- Worst-case latency is N cycles from accept to done.

## Configuration
- ROTATE_ALIGNER_MIN_DIR_EN:
  - Defined: on match with k > N/2, report dir=0 and sh_amt=N-k, the minimal-distance equivalent. Results with k ≤ N/2 are unchanged.
  - Undefined: always dir=1, sh_amt=k.
  - The search order and timing are identical in both builds.

## Structure
- Shared package rotate_pkg:
  - state enum {IDLE, SEARCH, DONE}
  - localparam for the dir encoding (DIR_LEFT=0, DIR_RIGHT=1)
  - width function for sh_amt
- One sub-module rot_r1: combinational N-bit rotate-right-by-one, instantiated for the cand update.
- FSM, counter and result registers live in rotate_aligner.

## Test plan
- din=8'b10011101, pattern=8'b10110011, start at E0 → done at cycle after E0+4, found=1, sh_amt=3, dir=1, dout=8'b10110011.
- din=8'b01110110, pattern=8'b10110011 → done after E0+6.
  - With the macro: sh_amt=3, dir=0.
  - Without the macro: sh_amt=5, dir=1.
- din=8'h00, pattern=8'hFF → done after E0+8, found=0, sh_amt=0, dout=8'h00; busy high for exactly 8 cycles.
- din=8'hAA, pattern=8'hAA → done after E0+1, sh_amt=0. Then din=8'h55 with start held high during DONE → second search starts with no IDLE gap and yields sh_amt=1.
- Start at E0, rst high at E0+2 → no done pulse; all outputs at reset values at E0+3. Start at E0+2 during that reset is ignored.
